// File: rtl/ling_serial_subtractor.sv
// Multi-cycle WIDTH-bit subtractor (diff = a - b): one 8-bit Ling adder slice per clock, LSB first.
// Optional signed-overflow output enabled by defining LING_SUB_OVF_EN.
module ling_serial_subtractor #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef LING_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NSLICE = WIDTH / 8;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

    if ((WIDTH % 8) != 0 || WIDTH < 8) begin : g_bad_width
        $error("ling_serial_subtractor: WIDTH must be a multiple of 8 and >= 8");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    typedef logic [NSLICE-1:0][7:0] slices_t;

    // Ling pseudo-carry h[i+1] = g[i] | t[i-1] & h[i]; the real carry is recovered as t[i] & h[i+1].
    function automatic logic [8:0] ling_add8(input logic [7:0] x, input logic [7:0] y,
                                              input logic cin);
        logic [7:0] g, p, t, s;
        logic [8:0] h, c, tt;
        g    = x & y;
        p    = x ^ y;
        t    = x | y;
        tt   = {t, 1'b1};
        h    = '0;
        c    = '0;
        s    = '0;
        h[0] = cin;
        c[0] = cin;
        for (int unsigned i = 0; i < 8; i++) begin
            h[i+1] = g[i] | (tt[i] & h[i]);
            c[i+1] = t[i] & h[i+1];
            s[i]   = p[i] ^ c[i];
        end
        return {c[8], s};
    endfunction

    state_t          state_q;
    slices_t         a_q, nb_q, diff_q;
    logic [IDXW-1:0] idx_q;
    logic            carry_q;
    logic            in_ready_q, out_valid_q, borrow_q;
    logic [8:0]      slice_d;
`ifdef LING_SUB_OVF_EN
    logic            ovf_q;
    logic            ovf_d;
`endif

    assign slice_d = ling_add8(a_q[idx_q], nb_q[idx_q], carry_q);

`ifdef LING_SUB_OVF_EN
    // b's sign is the complement of the stored nb MSB; the new MSB slice gives diff's sign.
    assign ovf_d = (a_q[NSLICE-1][7] == nb_q[NSLICE-1][7]) &&
                   (slice_d[7] != a_q[NSLICE-1][7]);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            nb_q        <= '0;
            diff_q      <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            borrow_q    <= 1'b0;
`ifdef LING_SUB_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q        <= a_in;
                        nb_q       <= ~b_in;
                        carry_q    <= 1'b1;
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= S_RUN;
                    end
                end
                S_RUN: begin
                    diff_q[idx_q] <= slice_d[7:0];
                    carry_q       <= slice_d[8];
                    idx_q         <= idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        borrow_q    <= ~slice_d[8];
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
`ifdef LING_SUB_OVF_EN
                        ovf_q       <= ovf_d;
`endif
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign borrow    = borrow_q;
`ifdef LING_SUB_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_ling_serial_subtractor.sv
// Scoreboard bench for ling_serial_subtractor (WIDTH=32): directed vectors, stall, reset abort, random.
// Checks ovf only when LING_SUB_OVF_EN is defined.
module tb_ling_serial_subtractor;

    localparam int W      = 32;
    localparam int NSLICE = W / 8;

    typedef struct {
        logic [W-1:0] d;
        logic         b;
        logic         o;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n, in_valid, in_ready, out_valid, out_ready, borrow, ovf;
    logic [W-1:0] a_in, b_in, diff;

    exp_t         sb_q[$];
    int unsigned  n_checks = 0;
    int unsigned  n_pass   = 0;
    int unsigned  cyc      = 0;
    int unsigned  or_mode  = 0;   // 0: out_ready=1, 1: random, 2: driven by directed code

    ling_serial_subtractor #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_in     (a_in),
        .b_in     (b_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .diff     (diff),
        .borrow   (borrow)
`ifdef LING_SUB_OVF_EN
        ,
        .ovf      (ovf)
`endif
    );

`ifndef LING_SUB_OVF_EN
    assign ovf = 1'b0;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.d = a - b;
        e.b = (a < b);
        e.o = (a[W-1] != b[W-1]) && (e.d[W-1] != a[W-1]);
        return e;
    endfunction

    function automatic logic [W-1:0] rand_op();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return W'($urandom);
        endcase
    endfunction

    always @(negedge clk) begin
        if (or_mode == 0) out_ready = 1'b1;
        else if (or_mode == 1) out_ready = 1'($urandom_range(0, 1));
    end

    // Monitor: samples 2 time units after the falling edge, ahead of the next rising edge.
    initial begin
        exp_t         e;
        logic         prev_hold = 1'b0, prev_hs = 1'b0, prev_ov = 1'b0, acc_pend = 1'b0;
        logic [W-1:0] prev_diff = '0;
        logic         prev_borrow = 1'b0, prev_ovf = 1'b0;
        int unsigned  acc_cyc = 0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                sb_q.delete();
                prev_hold = 1'b0; prev_hs = 1'b0; prev_ov = 1'b0; acc_pend = 1'b0;
                continue;
            end
            if (prev_hs) begin
                check("post_hs_out_valid", 64'(out_valid), 64'd0);
                check("post_hs_in_ready", 64'(in_ready), 64'd1);
            end
            if (in_valid && in_ready) begin
                acc_cyc  = cyc + 1;
                acc_pend = 1'b1;
            end
            if (out_valid && !prev_ov && acc_pend) begin
                check("latency", 64'(cyc - acc_cyc), 64'(NSLICE));
                acc_pend = 1'b0;
            end
            if (out_valid) check("in_ready_busy", 64'(in_ready), 64'd0);
            if (prev_hold) begin
                check("hold_diff", 64'(diff), 64'(prev_diff));
                check("hold_borrow", 64'(borrow), 64'(prev_borrow));
`ifdef LING_SUB_OVF_EN
                check("hold_ovf", 64'(ovf), 64'(prev_ovf));
`endif
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_result", 64'd1, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("diff", 64'(diff), 64'(e.d));
                    check("borrow", 64'(borrow), 64'(e.b));
`ifdef LING_SUB_OVF_EN
                    check("ovf", 64'(ovf), 64'(e.o));
`endif
                end
            end
            prev_hs     = out_valid && out_ready;
            prev_hold   = out_valid && !out_ready;
            prev_ov     = out_valid;
            prev_diff   = diff;
            prev_borrow = borrow;
            prev_ovf    = ovf;
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
        int unsigned n = 0;
        @(negedge clk);
        a_in     = a;
        b_in     = b;
        in_valid = 1'b1;
        #2;
        while (!in_ready && n < 500) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 64'd1, 64'd0);
        end else begin
            sb_q.push_back(model(a, b));
            @(posedge clk);
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int unsigned n = 0;
        while ((sb_q.size() != 0 || !in_ready) && n < 2000) begin
            @(negedge clk);
            #3;
            n++;
        end
        if (n >= 2000) check("drain_timeout", 64'd1, 64'd0);
    endtask

    initial begin
        int unsigned n;
        logic [W-1:0] a, b;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_in      = '0;
        b_in      = '0;
        or_mode   = 2;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_diff", 64'(diff), 64'd0);
        check("rst_borrow", 64'(borrow), 64'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        or_mode = 0;

        send(32'h0000_0005, 32'h0000_0003);
        send(32'h0000_0000, 32'h0000_0001);
        send(32'h0000_0100, 32'h0000_0001);
        send(32'h8000_0000, 32'h0000_0001);
        send(32'h1234_5678, 32'h1234_5678);
        send(32'hCAFE_F00D, 32'h0000_0000);
        wait_idle();

        // Stall in DONE with in_valid pulses that must not be captured.
        or_mode   = 2;
        out_ready = 1'b0;
        send(32'hDEAD_BEEF, 32'h1234_5678);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            #3;
            n++;
        end
        check("stall_out_valid", 64'(out_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = ((i % 2) == 0);
            a_in     = W'($urandom);
            b_in     = W'($urandom);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        or_mode   = 0;
        wait_idle();

        // Reset while RUN is on its second slice.
        send(32'h0000_0001, 32'h0000_0002);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_diff", 64'(diff), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send(32'd7, 32'd7);
        wait_idle();

        or_mode = 1;
        for (int k = 0; k < 3000; k++) begin
            a = rand_op();
            b = ($urandom_range(0, 7) == 0) ? a : rand_op();
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            send(a, b);
        end
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
